// File: rtl/phold_engine.sv
// PHOLD discrete-event engine: seeds an event pool, repeatedly retires the minimum-timestamp
// event with an 8-byte read-modify-write of its LP counter over MC port 0, then reschedules it.
module phold_engine #(
    parameter int NUM_MC_PORTS    = 16,
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int QDEPTH          = 16
) (
    input  logic                                    clk,
    input  logic                                    i_reset,
    input  logic [15:0]                             sim_end,
    input  logic [47:0]                             addr,
    input  logic [7:0]                              num_init_events,
    input  logic [7:0]                              lp_mask,
    output logic [15:0]                             gvt,
    output logic                                    rtn_vld,
    output logic [63:0]                             total_cycles,
    output logic [NUM_MC_PORTS-1:0]                 mc_rq_vld,
    output logic [NUM_MC_PORTS*3-1:0]               mc_rq_cmd,
    output logic [NUM_MC_PORTS*4-1:0]               mc_rq_scmd,
    output logic [NUM_MC_PORTS*48-1:0]              mc_rq_vadr,
    output logic [NUM_MC_PORTS*2-1:0]               mc_rq_size,
    output logic [NUM_MC_PORTS*MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
    output logic [NUM_MC_PORTS*64-1:0]              mc_rq_data,
    output logic [NUM_MC_PORTS-1:0]                 mc_rq_flush,
    input  logic [NUM_MC_PORTS-1:0]                 mc_rq_stall,
    input  logic [NUM_MC_PORTS-1:0]                 mc_rs_vld,
    input  logic [NUM_MC_PORTS*3-1:0]               mc_rs_cmd,
    input  logic [NUM_MC_PORTS*4-1:0]               mc_rs_scmd,
    input  logic [NUM_MC_PORTS*MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
    input  logic [NUM_MC_PORTS*64-1:0]              mc_rs_data,
    output logic [NUM_MC_PORTS-1:0]                 mc_rs_stall
);

    localparam int SLOT_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    localparam logic [2:0] CMD_RD      = 3'd1;
    localparam logic [2:0] CMD_WR      = 3'd2;
    localparam logic [2:0] RS_RD_DATA  = 3'd2;
    localparam logic [2:0] RS_WR_CMPLT = 3'd3;

    typedef enum logic [3:0] {
        S_INIT, S_SELECT, S_RD, S_RDW, S_WR, S_WRW, S_RESCHED, S_DONE, S_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          init_idx_q, init_idx_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [15:0]         cur_ts_q, cur_ts_d;
    logic [7:0]          cur_lp_q, cur_lp_d;
    logic [63:0]         data_q, data_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [15:0]         gvt_q, gvt_d;
    logic [63:0]         cycles_q, cycles_d;

    logic [QDEPTH-1:0]   valid_q;
    logic [15:0]         ts_q [QDEPTH];
    logic [7:0]          lp_q [QDEPTH];

    logic                pool_we;
    logic [SLOT_W-1:0]   pool_idx;
    logic [15:0]         pool_ts;
    logic [7:0]          pool_lp;

    logic                rq_vld;
    logic [2:0]          rq_cmd;
    logic [47:0]         rq_vadr;
    logic [1:0]          rq_size;
    logic [63:0]         rq_data;

    logic                min_found;
    logic [SLOT_W-1:0]   min_slot;
    logic [15:0]         min_ts;

    logic [7:0]          n_events;
    logic [16:0]         ts_sum;
    logic [15:0]         ts_next;
    logic [15:0]         lfsr_next;
    logic                unused_inputs;

    assign n_events  = (num_init_events > 8'(QDEPTH)) ? 8'(QDEPTH) : num_init_events;
    assign ts_sum    = {1'b0, cur_ts_q} + 17'd1 + {13'd0, lfsr_q[3:0]};
    assign ts_next   = ts_sum[16] ? 16'hFFFF : ts_sum[15:0];
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // Strict less-than while scanning upward makes ties resolve to the lowest index.
    always_comb begin
        min_found = 1'b0;
        min_slot  = '0;
        min_ts    = 16'hFFFF;
        for (int i = 0; i < QDEPTH; i++) begin
            if (valid_q[i] && (!min_found || ts_q[i] < min_ts)) begin
                min_found = 1'b1;
                min_slot  = SLOT_W'(i);
                min_ts    = ts_q[i];
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        slot_d     = slot_q;
        cur_ts_d   = cur_ts_q;
        cur_lp_d   = cur_lp_q;
        data_d     = data_q;
        lfsr_d     = lfsr_q;
        gvt_d      = gvt_q;
        cycles_d   = (state_q != S_HALT) ? cycles_q + 64'd1 : cycles_q;
        pool_we    = 1'b0;
        pool_idx   = '0;
        pool_ts    = '0;
        pool_lp    = '0;
        rq_vld     = 1'b0;
        rq_cmd     = '0;
        rq_vadr    = '0;
        rq_size    = '0;
        rq_data    = '0;
        rtn_vld    = 1'b0;

        unique case (state_q)
            S_INIT: begin
                if (n_events == 8'd0) begin
                    state_d = S_SELECT;
                end else begin
                    pool_we    = 1'b1;
                    pool_idx   = init_idx_q[SLOT_W-1:0];
                    pool_lp    = init_idx_q & lp_mask;
                    init_idx_d = init_idx_q + 8'd1;
                    if (init_idx_q == n_events - 8'd1) state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (!min_found || min_ts >= sim_end) begin
                    gvt_d   = min_found ? min_ts : sim_end;
                    state_d = S_DONE;
                end else begin
                    slot_d   = min_slot;
                    cur_ts_d = min_ts;
                    cur_lp_d = lp_q[min_slot];
                    state_d  = S_RD;
                end
            end
            S_RD, S_WR: begin
                rq_vld  = 1'b1;
                rq_cmd  = (state_q == S_RD) ? CMD_RD : CMD_WR;
                rq_vadr = addr + {37'd0, cur_lp_q, 3'b000};
                rq_size = 2'd3;
                rq_data = (state_q == S_RD) ? 64'd0 : data_q + 64'd1;
                if (!mc_rq_stall[0]) state_d = (state_q == S_RD) ? S_RDW : S_WRW;
            end
            S_RDW: begin
                if (mc_rs_vld[0] && mc_rs_cmd[2:0] == RS_RD_DATA) begin
                    data_d  = mc_rs_data[63:0];
                    state_d = S_WR;
                end
            end
            S_WRW: begin
                if (mc_rs_vld[0] && mc_rs_cmd[2:0] == RS_WR_CMPLT) state_d = S_RESCHED;
            end
            S_RESCHED: begin
                pool_we  = 1'b1;
                pool_idx = slot_q;
                pool_ts  = ts_next;
                pool_lp  = lfsr_q[15:8] & lp_mask;
                lfsr_d   = lfsr_next;
                state_d  = S_SELECT;
            end
            S_DONE: begin
                rtn_vld = 1'b1;
                state_d = S_HALT;
            end
            S_HALT: ;
            default: state_d = S_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
            slot_q     <= '0;
            cur_ts_q   <= '0;
            cur_lp_q   <= '0;
            data_q     <= '0;
            lfsr_q     <= 16'hACE1;
            gvt_q      <= '0;
            cycles_q   <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            slot_q     <= slot_d;
            cur_ts_q   <= cur_ts_d;
            cur_lp_q   <= cur_lp_d;
            data_q     <= data_d;
            lfsr_q     <= lfsr_d;
            gvt_q      <= gvt_d;
            cycles_q   <= cycles_d;
            if (pool_we) valid_q[pool_idx] <= 1'b1;
        end
    end

    // NOTE: pool payload is not reset; an entry's ts/lp are only read once its valid bit is set.
    always_ff @(posedge clk) begin
        if (!i_reset && pool_we) begin
            ts_q[pool_idx] <= pool_ts;
            lp_q[pool_idx] <= pool_lp;
        end
    end

    assign gvt          = gvt_q;
    assign total_cycles = cycles_q;

    assign mc_rq_vld    = NUM_MC_PORTS'(rq_vld);
    assign mc_rq_cmd    = (NUM_MC_PORTS*3)'(rq_cmd);
    assign mc_rq_scmd   = '0;
    assign mc_rq_vadr   = (NUM_MC_PORTS*48)'(rq_vadr);
    assign mc_rq_size   = (NUM_MC_PORTS*2)'(rq_size);
    assign mc_rq_rtnctl = rq_vld ? (NUM_MC_PORTS*MC_RTNCTL_WIDTH)'(slot_q) : '0;
    assign mc_rq_data   = (NUM_MC_PORTS*64)'(rq_data);
    assign mc_rq_flush  = '0;
    assign mc_rs_stall  = '0;

    assign unused_inputs = ^{mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data};

endmodule

// File: tb/tb_phold_engine.sv
// Directed bench for phold_engine: a port-0 memory model with a junk response before each real one,
// plus per-scenario tasks with hand-computed expectations.
module tb_phold_engine;

    localparam int N  = 16;
    localparam int RW = 32;

    logic               clk = 1'b0;
    logic               i_reset = 1'b1;
    logic [15:0]        sim_end = '0;
    logic [47:0]        addr = '0;
    logic [7:0]         num_init_events = '0;
    logic [7:0]         lp_mask = '0;
    logic [15:0]        gvt;
    logic               rtn_vld;
    logic [63:0]        total_cycles;
    logic [N-1:0]       mc_rq_vld;
    logic [N*3-1:0]     mc_rq_cmd;
    logic [N*4-1:0]     mc_rq_scmd;
    logic [N*48-1:0]    mc_rq_vadr;
    logic [N*2-1:0]     mc_rq_size;
    logic [N*RW-1:0]    mc_rq_rtnctl;
    logic [N*64-1:0]    mc_rq_data;
    logic [N-1:0]       mc_rq_flush;
    logic [N-1:0]       mc_rq_stall = '0;
    logic [N-1:0]       mc_rs_vld = '0;
    logic [N*3-1:0]     mc_rs_cmd = '0;
    logic [N*4-1:0]     mc_rs_scmd = '0;
    logic [N*RW-1:0]    mc_rs_rtnctl = '0;
    logic [N*64-1:0]    mc_rs_data = '0;
    logic [N-1:0]       mc_rs_stall;

    int n_cmp = 0;
    int n_err = 0;

    // memory model state
    logic [63:0] mem [256];
    int          n_rd, n_wr, n_vld_cycles, n_stalled, stall_left;
    int          rd_lp [64];
    bit          rsp_pend = 1'b0;
    int          rsp_cnt;
    logic [2:0]  rsp_cmd;
    logic [63:0] rsp_data;
    bit          prev_stalled = 1'b0;
    logic [2:0]  prev_cmd;
    logic [47:0] prev_vadr;
    logic [63:0] prev_data;
    logic [1:0]  prev_size;
    logic [RW-1:0] prev_rtnctl;

    phold_engine #(.NUM_MC_PORTS(N), .MC_RTNCTL_WIDTH(RW), .QDEPTH(16)) dut (
        .clk(clk), .i_reset(i_reset), .sim_end(sim_end), .addr(addr),
        .num_init_events(num_init_events), .lp_mask(lp_mask),
        .gvt(gvt), .rtn_vld(rtn_vld), .total_cycles(total_cycles),
        .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
        .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
        .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
        .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
        .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data), .mc_rs_stall(mc_rs_stall)
    );

    always #5 clk = ~clk;

    // Memory model, evaluated mid-cycle: answers each accepted request two cycles later,
    // preceded by a one-cycle response carrying an irrelevant cmd that must be ignored.
    always @(negedge clk) begin
        logic [47:0] off;
        logic [7:0]  lp;
        bit          stall;
        mc_rs_vld  = '0;
        mc_rs_cmd  = '0;
        mc_rs_data = '0;
        if (rsp_pend) begin
            if (rsp_cnt == 0) begin
                mc_rs_vld[0]     = 1'b1;
                mc_rs_cmd[2:0]   = rsp_cmd;
                mc_rs_data[63:0] = rsp_data;
                rsp_pend         = 1'b0;
            end else begin
                if (rsp_cnt == 1) begin
                    mc_rs_vld[0]     = 1'b1;
                    mc_rs_cmd[2:0]   = 3'd0;
                    mc_rs_data[63:0] = 64'hDEAD_BEEF_0BAD_F00D;
                end
                rsp_cnt--;
            end
        end
        if (i_reset) begin
            mc_rq_stall  = '0;
            prev_stalled = 1'b0;
        end else begin
            n_cmp++;
            if (mc_rq_vld[N-1:1] !== '0 || mc_rq_flush !== '0 || mc_rs_stall !== '0 || mc_rq_scmd !== '0) begin
                n_err++;
                $display("FAIL idle_ports: vld=%h flush=%h rs_stall=%h scmd=%h required all zero",
                         mc_rq_vld, mc_rq_flush, mc_rs_stall, mc_rq_scmd);
            end
            stall = (stall_left > 0);
            mc_rq_stall[0] = stall;
            if (mc_rq_vld[0] === 1'b1) begin
                n_vld_cycles++;
                if (prev_stalled) begin
                    n_cmp++;
                    if (mc_rq_cmd[2:0] !== prev_cmd || mc_rq_vadr[47:0] !== prev_vadr ||
                        mc_rq_data[63:0] !== prev_data || mc_rq_size[1:0] !== prev_size ||
                        mc_rq_rtnctl[RW-1:0] !== prev_rtnctl) begin
                        n_err++;
                        $display("FAIL stall_hold: cmd=%0d vadr=%h got, held cmd=%0d vadr=%h required",
                                 mc_rq_cmd[2:0], mc_rq_vadr[47:0], prev_cmd, prev_vadr);
                    end
                end
                if (stall) begin
                    stall_left--;
                    n_stalled++;
                    prev_stalled = 1'b1;
                    prev_cmd     = mc_rq_cmd[2:0];
                    prev_vadr    = mc_rq_vadr[47:0];
                    prev_data    = mc_rq_data[63:0];
                    prev_size    = mc_rq_size[1:0];
                    prev_rtnctl  = mc_rq_rtnctl[RW-1:0];
                end else begin
                    prev_stalled = 1'b0;
                    off = mc_rq_vadr[47:0] - addr;
                    lp  = off[10:3];
                    n_cmp++;
                    if (off[2:0] !== 3'd0 || off[47:3] > {37'd0, lp_mask} || mc_rq_size[1:0] !== 2'd3) begin
                        n_err++;
                        $display("FAIL rq_addr: vadr=%h size=%0d got, addr+8*lp (lp<=%h) size=3 required",
                                 mc_rq_vadr[47:0], mc_rq_size[1:0], lp_mask);
                    end
                    if (mc_rq_cmd[2:0] == 3'd1) begin
                        if (n_rd < 64) rd_lp[n_rd] = int'(lp);
                        n_rd++;
                        rsp_cmd  = 3'd2;
                        rsp_data = mem[lp];
                    end else begin
                        n_cmp++;
                        if (mc_rq_cmd[2:0] !== 3'd2 || mc_rq_data[63:0] !== mem[lp] + 64'd1) begin
                            n_err++;
                            $display("FAIL rq_write: cmd=%0d data=%0d got, cmd=2 data=%0d required",
                                     mc_rq_cmd[2:0], mc_rq_data[63:0], mem[lp] + 64'd1);
                        end
                        n_wr++;
                        mem[lp]  = mc_rq_data[63:0];
                        rsp_cmd  = 3'd3;
                        rsp_data = '0;
                    end
                    rsp_pend = 1'b1;
                    rsp_cnt  = 2;
                end
            end else begin
                prev_stalled = 1'b0;
            end
        end
    end

    // Puts the engine in reset with a fresh configuration and clean model, then releases it.
    task automatic start_run(input logic [7:0] n, input logic [15:0] send, input logic [7:0] mask,
                             input logic [47:0] base, input int stalls);
        @(negedge clk);
        i_reset = 1'b1;
        num_init_events = n;
        sim_end = send;
        lp_mask = mask;
        addr = base;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 256; i++) mem[i] = '0;
        n_rd = 0; n_wr = 0; n_vld_cycles = 0; n_stalled = 0; stall_left = stalls;
        i_reset = 1'b0;
    endtask

    // Called right after release; cycles is the reset-release-to-done count including the done cycle.
    task automatic wait_done(input string name, output int cycles);
        int k = 0;
        while (rtn_vld !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        cycles = k + 1;
        n_cmp++;
        if (rtn_vld !== 1'b1) begin
            n_err++;
            $display("FAIL %s_timeout: rtn_vld=%b after %0d cycles, required 1", name, rtn_vld, k);
        end
        @(negedge clk);
        n_cmp++;
        if (rtn_vld !== 1'b0 || total_cycles !== 64'(cycles)) begin
            n_err++;
            $display("FAIL %s_done: rtn_vld=%b total_cycles=%0d got, rtn_vld=0 total_cycles=%0d required",
                     name, rtn_vld, total_cycles, cycles);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (gvt !== '0 || rtn_vld !== 1'b0 || total_cycles !== '0 || mc_rq_vld !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: gvt=%0d rtn=%b tc=%0d vld=%h, required all 0",
                     gvt, rtn_vld, total_cycles, mc_rq_vld);
        end
    endtask

    task automatic test_empty_pool();
        int c;
        start_run(8'd0, 16'd100, 8'h0F, 48'h0000_1000_0000, 0);
        wait_done("empty", c);
        n_cmp++;
        if (c !== 3 || gvt !== 16'd100 || n_vld_cycles !== 0) begin
            n_err++;
            $display("FAIL empty_run: cycles=%0d gvt=%0d rq_cycles=%0d got, 3/100/0 required",
                     c, gvt, n_vld_cycles);
        end
    endtask

    // Seed ACE1: lfsr[3:0]=1 so the event is rescheduled to 0+1+1=2; two-cycle memory latency gives 13 cycles.
    task automatic test_single_event(input int stalls, input int exp_cycles);
        int c;
        start_run(8'd1, 16'd1, 8'h00, 48'h0000_ABCD_E000, stalls);
        mem[0] = 64'd5;
        wait_done("single", c);
        n_cmp++;
        if (c !== exp_cycles || gvt !== 16'd2) begin
            n_err++;
            $display("FAIL single_run: cycles=%0d gvt=%0d got, cycles=%0d gvt=2 required", c, gvt, exp_cycles);
        end
        n_cmp++;
        if (n_rd !== 1 || n_wr !== 1 || mem[0] !== 64'd6 || rd_lp[0] !== 0 || n_stalled !== stalls) begin
            n_err++;
            $display("FAIL single_mem: rd=%0d wr=%0d mem0=%0d stalled=%0d got, 1/1/6/%0d required",
                     n_rd, n_wr, mem[0], n_stalled, stalls);
        end
    endtask

    // Base near the top of the 48-bit space so lp 2 and 3 wrap to low addresses.
    task automatic test_multi_lp();
        int c;
        longint sum;
        start_run(8'd4, 16'd50, 8'h03, 48'hFFFF_FFFF_FFF0, 0);
        wait_done("multi", c);
        sum = 0;
        for (int i = 0; i < 4; i++) sum += longint'(mem[i]);
        n_cmp++;
        if (gvt < 16'd50 || gvt > 16'd65) begin
            n_err++;
            $display("FAIL multi_gvt: gvt=%0d got, 50..65 required", gvt);
        end
        n_cmp++;
        if (n_rd !== n_wr || sum !== longint'(n_wr) || n_rd < 4) begin
            n_err++;
            $display("FAIL multi_count: rd=%0d wr=%0d sum=%0d got, rd=wr=sum>=4 required", n_rd, n_wr, sum);
        end
    endtask

    // 40 requested events clamp to 16 with ts=0; each is processed once, lowest slot first.
    task automatic test_clamp();
        int c;
        int bad;
        start_run(8'd40, 16'd1, 8'hFF, 48'h0000_0000_8000, 0);
        wait_done("clamp", c);
        bad = 0;
        for (int i = 0; i < 16; i++) if (rd_lp[i] !== i || mem[i] !== 64'd1) bad++;
        for (int i = 16; i < 40; i++) if (mem[i] !== 64'd0) bad++;
        n_cmp++;
        if (n_rd !== 16 || n_wr !== 16 || bad !== 0) begin
            n_err++;
            $display("FAIL clamp_events: rd=%0d wr=%0d bad_slots=%0d got, 16/16/0 required", n_rd, n_wr, bad);
        end
        n_cmp++;
        if (gvt < 16'd1 || gvt > 16'd16) begin
            n_err++;
            $display("FAIL clamp_gvt: gvt=%0d got, 1..16 required", gvt);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rtn_vld !== 1'b0 || total_cycles !== 64'(c)) begin
            n_err++;
            $display("FAIL clamp_hold: rtn=%b tc=%0d got, 0/%0d required", rtn_vld, total_cycles, c);
        end
    endtask

    task automatic test_reset_mid_run();
        int k;
        int c;
        start_run(8'd4, 16'd50, 8'h03, 48'h0000_0200_0000, 0);
        k = 0;
        while (n_rd < 1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (n_rd < 1) begin
            n_err++;
            $display("FAIL midrst_read: reads=%0d got, 1 required", n_rd);
        end
        i_reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (gvt !== '0 || rtn_vld !== 1'b0 || total_cycles !== '0 || mc_rq_vld !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs: gvt=%0d rtn=%b tc=%0d vld=%h, required all 0",
                     gvt, rtn_vld, total_cycles, mc_rq_vld);
        end
        start_run(8'd4, 16'd50, 8'h03, 48'h0000_0200_0000, 0);
        wait_done("midrst", c);
        n_cmp++;
        if (gvt < 16'd50 || gvt > 16'd65 || n_rd !== n_wr || n_rd < 4 ||
            mem[0] + mem[1] + mem[2] + mem[3] !== 64'(n_wr)) begin
            n_err++;
            $display("FAIL midrst_rerun: gvt=%0d rd=%0d wr=%0d got, gvt 50..65 rd=wr=counter sum required",
                     gvt, n_rd, n_wr);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        n_rd = 0; n_wr = 0; n_vld_cycles = 0; n_stalled = 0; stall_left = 0;
        repeat (3) @(negedge clk);
        test_reset();
        test_empty_pool();
        test_single_event(0, 13);
        test_multi_lp();
        test_single_event(10, 23);
        test_clamp();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/phold_engine.md
Name: phold_engine

Overview:
- Self-contained PHOLD discrete-event-simulation engine for the coprocessor personality.
- After reset it seeds an on-chip event pool and repeatedly processes the minimum-timestamp event.
- Each processed event does an 8-byte read-modify-write of a per-LP counter in host memory via MC port 0, then reschedules itself with a pseudo-random delay and destination.
- It stops when the GVT (minimum pending timestamp) reaches sim_end, reports the GVT and total cycles, and pulses rtn_vld.

Parameters:
- NUM_MC_PORTS, 16, number of MC request/response ports (bus replication factor).
- MC_RTNCTL_WIDTH, 32, width of rtnctl per port.
- QDEPTH, 16, event pool entries.

Ports:
- clk  in  1  clock
- i_reset  in  1  synchronous active-high reset; deassertion starts the run
- sim_end  in  16  end GVT
- addr  in  48  base byte address of LP counter array (8 B per LP)
- num_init_events  in  8  initial events; values above QDEPTH are clamped to QDEPTH
- lp_mask  in  8  LP index mask
- gvt  out  16  final GVT
- rtn_vld  out  1  one-cycle done pulse
- total_cycles  out  64  cycles from reset release to done
- mc_rq_vld/cmd/scmd/vadr/size/rtnctl/data/flush  out  NUM_MC_PORTS x {1,3,4,48,2,W,64,1}  MC request buses
- mc_rq_stall  in  NUM_MC_PORTS  request backpressure
- mc_rs_vld/cmd/scmd/rtnctl/data  in  NUM_MC_PORTS x {1,3,4,W,64}  MC responses
- mc_rs_stall  out  NUM_MC_PORTS  response backpressure

Behaviour:
- Reset: all outputs 0.
  - LFSR seeded to 16'hACE1; pool cleared; state INIT.
  - Inputs must be stable while i_reset is low.
- Only port 0 is used. Ports 1..N-1 rq_vld=0. All rq_flush=0 and all rs_stall=0. scmd=0 always.
- INIT: writes entries 0..n-1 one per cycle, where n=min(num_init_events,QDEPTH).
  - Entry i = {valid=1, ts=0, lp=i[7:0]&lp_mask}.
  - Go to SELECT.
- SELECT (1 cycle): combinational minimum over valid entries; ties go to the lowest index.
  - If no valid entry, or min ts >= sim_end: gvt<=(no entry ? sim_end : min ts), go to DONE.
  - Otherwise latch slot, ts, lp and go to RD.
- RD: assert rq_vld with cmd=1 (read), size=3 (8 B), vadr=addr+{lp,3'b000} (48-bit wrap), rtnctl=slot index zero-extended.
  - Hold all fields until a cycle with vld && !stall; that cycle is the accept. Then go to RDW.
- RDW: wait for rs_vld with rs_cmd=2 (read data); latch data. Responses with other cmd are ignored.
- WR: cmd=2 (write), size=3, same vadr, data=latched+1 (64-bit wrap), same stall rule. Then go to WRW.
- WRW: wait for rs_vld with rs_cmd=3 (write complete).
- RESCHED (1 cycle): overwrite the slot with ts'=ts+1+lfsr[3:0], saturating at 16'hFFFF, and lp'=lfsr[15:8]&lp_mask.
  - Advance the LFSR once (Galois, taps 16'hB400, shift right).
  - Go to SELECT.
- DONE: rtn_vld=1 for exactly the entry cycle; then it stays 0.
  - gvt and total_cycles hold; engine idle until reset.
- total_cycles: counts every cycle with reset low, until and including the DONE-entry cycle, then frozen.
- Event count is constant (one consumed, one produced), so the pool never overflows.
- Reset mid-run aborts immediately. An outstanding MC response arriving after reset is ignored.

Test Plan:
- num_init_events=0, sim_end=100, release reset -> rtn_vld pulse within 3 cycles, gvt=100, no mc_rq_vld ever.
- num_init_events=1, sim_end=1, lp_mask=0, memory word=5 at addr -> one read of addr, one write of 6, then rtn_vld, gvt = first rescheduled ts (>=1).
- num_init_events=4, lp_mask=3, sim_end=50, memory model returns data -> every request vadr=addr+8*lp with lp<=3; final gvt>=50; sum of counter increments equals number of processed events.
- Hold mc_rq_stall=1 for 10 cycles during RD -> vld/vadr/cmd stable throughout, exactly one request accepted.
- num_init_events=40 -> exactly 16 events (clamped), rtn_vld single-cycle, total_cycles equals measured release-to-done count.
- Assert i_reset mid-RDW, release -> restarts from INIT, outputs 0 during reset, run completes normally.
